pr_avmm_freeze_bridge: RTL and testbench
========================================

PR_AVMM_FREEZE_BRIDGE -- requirements
Module: pr_avmm_freeze_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, AVMM address width.
REQ-002 SHALL have parameter DATA_W, default 32, AVMM data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight reads (1..15).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, read-response timeout in clk cycles (>=2).
REQ-005 SHALL have parameter TIMEOUT_DATA, default 32'hDEADBEEF, readdata returned on timeout.
REQ-006 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports s_address/s_writedata/s_write/s_read  input  ADDR_W/DATA_W/1/1  AVMM slave request from the PR user region.
REQ-009 SHALL have ports s_waitrequest/s_readdata/s_readdatavalid  output  1/DATA_W/1  AVMM slave response to the PR user region.
REQ-010 SHALL have ports m_address/m_writedata/m_write/m_read  output  ADDR_W/DATA_W/1/1  AVMM master request to the static NoC.
REQ-011 SHALL have ports m_waitrequest/m_readdata/m_readdatavalid  input  1/DATA_W/1  AVMM master response from the NoC.
REQ-012 SHALL have port freeze  input  1  PR freeze request from the PR controller.
REQ-013 SHALL have port freeze_ack  output  1  bridge quiesced.
REQ-014 SHALL have ports err_clear  input  1  and err_timeout  output  1  sticky timeout flag and its clear.

Function
REQ-015 SHALL implement a request FSM with states IDLE and ISSUE.
REQ-016 SHALL drive s_waitrequest=0 only when state==IDLE, freeze==0, and (s_read==0 or rd_cnt<MAX_OUTSTANDING); otherwise 1.
REQ-017 SHALL, in IDLE with s_write or s_read asserted and s_waitrequest==0, register address/data/command and go to ISSUE next cycle.
REQ-018 SHALL treat s_write and s_read both asserted as a write only (read dropped, no response).
REQ-019 SHALL in ISSUE drive m_* from the registered request and return to IDLE on the first cycle m_waitrequest==0.
REQ-020 SHALL drive m_write=m_read=0 in IDLE; minimum request latency s-accept to m-presentation is 1 cycle.
REQ-021 SHALL increment rd_cnt when a read leaves ISSUE and decrement it on each forwarded or synthesized response; simultaneous issue and response leave rd_cnt unchanged.
REQ-022 SHALL forward m_readdatavalid/m_readdata to s_readdatavalid/s_readdata with 1 cycle registered latency, in order, regardless of freeze.
REQ-023 SHALL run a timer while rd_cnt>0, clearing it on every response and holding it at 0 while rd_cnt==0.
REQ-024 SHALL, when the timer reaches TIMEOUT_CYCLES-1, emit one s_readdatavalid with TIMEOUT_DATA, decrement rd_cnt, increment drop_cnt, set err_timeout, and clear the timer.
REQ-025 SHALL discard (not forward, no rd_cnt change) any m_readdatavalid arriving while drop_cnt>0, decrementing drop_cnt.
REQ-026 SHALL give a real response priority over a timeout expiring in the same cycle (no synthesized response).
REQ-027 SHALL let a request captured before freeze rises complete normally.
REQ-028 SHALL assert freeze_ack = freeze && state==IDLE && rd_cnt==0, registered (1 cycle late), deasserted the cycle after freeze falls.
REQ-029 SHALL clear err_timeout on err_clear, with a same-cycle new timeout taking priority (stays set).

Reset
REQ-030 SHALL on rst low asynchronously set state=IDLE, rd_cnt=0, drop_cnt=0, timer=0, err_timeout=0, freeze_ack=0, s_readdatavalid=0, s_readdata=0, m_write=m_read=0, m_address=m_writedata=0.
REQ-031 SHALL after rst deasserts drive s_waitrequest per REQ-016 from the first clk edge.

Structure
REQ-032 SHALL place the FSM state enum and default constants (ADDR_W, DATA_W, TIMEOUT_DATA) in shared package pr_bridge_pkg.
REQ-033 SHALL implement rd_cnt, timer and drop_cnt in sub-module pr_avmm_rsp_tracker.

Verification
REQ-034 SHALL verify: write addr 0x00010, data 0x12345678, m_waitrequest=1 for 3 cycles -> m_write held 3 cycles with same address/data, single NoC write.
REQ-035 SHALL verify: 5 back-to-back reads, no responses, MAX_OUTSTANDING=4 -> 4 reads issued, 5th held with s_waitrequest=1 until first response.
REQ-036 SHALL verify: one read, no response for 1024 cycles -> s_readdatavalid with 0xDEADBEEF, err_timeout=1; late m_readdatavalid dropped.
REQ-037 SHALL verify: freeze raised during ISSUE with 2 reads in flight -> request completes, freeze_ack rises 1 cycle after last response, new requests blocked.
REQ-038 SHALL verify: rst pulled low mid-ISSUE with rd_cnt=3 -> all outputs at reset values immediately, rd_cnt=0 after release.
REQ-039 SHALL verify: timeout expiry coinciding with m_readdatavalid data 0xA5A5A5A5 -> 0xA5A5A5A5 forwarded, err_timeout remains 0.

Source files
------------

// File: rtl/pr_bridge_pkg.sv
// Shared request-FSM type and default interface constants for the
// partial-reconfiguration AVMM freeze bridge.
package pr_bridge_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } req_state_t;

  localparam int          DEF_ADDR_W       = 20;
  localparam int          DEF_DATA_W       = 32;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/pr_avmm_rsp_tracker.sv
// Read-response tracker: outstanding-read count, response timeout with
// synthesized error data, and discard of responses that arrive after their timeout.
module pr_avmm_rsp_tracker #(
  parameter int                DATA_W          = 32,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                TIMEOUT_CYCLES  = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA    = '1,
  parameter int                CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              err_clear,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              s_readdatavalid,
  output logic [DATA_W-1:0] s_readdata,
  output logic              err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] drop_cnt;
  logic             fwd;
  logic             discard;
  logic             expire;
  logic             dec;

  // A real response always wins over an expiry in the same cycle.
  always_comb begin
    discard = rsp_valid && (drop_cnt != '0);
    fwd     = rsp_valid && (drop_cnt == '0);
    expire  = !fwd && (rd_cnt != '0) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    dec     = (fwd && (rd_cnt != '0)) || expire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
    end else if (rd_issue && !dec) begin
      rd_cnt <= rd_cnt + CNT_W'(1);
    end else if (!rd_issue && dec) begin
      rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if ((rd_cnt == '0) || fwd || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Saturates so a dead NoC slave cannot wrap the late-response count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (expire && !discard && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (discard && !expire) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
    end else begin
      s_readdatavalid <= fwd || expire;
      if (fwd) begin
        s_readdata <= rsp_data;
      end else if (expire) begin
        s_readdata <= TIMEOUT_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_timeout <= 1'b0;
    end else if (expire) begin
      err_timeout <= 1'b1;
    end else if (err_clear) begin
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/pr_avmm_freeze_bridge.sv
// AVMM bridge between a PR user region and the static NoC; single-request
// forwarding with read-depth limiting, freeze quiescing and read timeout.
module pr_avmm_freeze_bridge
  import pr_bridge_pkg::*;
#(
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter int                DATA_W          = DEF_DATA_W,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                TIMEOUT_CYCLES  = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA    = DATA_W'(DEF_TIMEOUT_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic              s_write,
  input  logic              s_read,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_write,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              freeze,
  output logic              freeze_ack,
  input  logic              err_clear,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  req_state_t       state;
  req_state_t       state_next;
  logic [CNT_W-1:0] rd_cnt;
  logic             accept;
  logic             issue_done;
  logic             rd_issue;
  logic             ack_next;

  always_comb begin
    s_waitrequest = 1'b1;
    if ((state == IDLE) && !freeze &&
        (!s_read || (rd_cnt < CNT_W'(MAX_OUTSTANDING)))) begin
      s_waitrequest = 1'b0;
    end
    accept     = (state == IDLE) && (s_write || s_read) && !s_waitrequest;
    issue_done = (state == ISSUE) && !m_waitrequest;
    rd_issue   = issue_done && m_read;
    ack_next   = freeze && (state == IDLE) && (rd_cnt == '0);
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (!m_waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The m_* registers double as the captured request; a simultaneous
  // write+read is forwarded as a write only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_address   <= '0;
      m_writedata <= '0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
    end else if (accept) begin
      m_address   <= s_address;
      m_writedata <= s_writedata;
      m_write     <= s_write;
      m_read      <= s_read && !s_write;
    end else if (issue_done) begin
      m_write <= 1'b0;
      m_read  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_ack <= 1'b0;
    end else begin
      freeze_ack <= ack_next;
    end
  end

  pr_avmm_rsp_tracker #(
    .DATA_W         (DATA_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_DATA   (TIMEOUT_DATA),
    .CNT_W          (CNT_W)
  ) u_rsp_tracker (
    .clk            (clk),
    .rst            (rst),
    .rd_issue       (rd_issue),
    .rsp_valid      (m_readdatavalid),
    .rsp_data       (m_readdata),
    .err_clear      (err_clear),
    .rd_cnt         (rd_cnt),
    .s_readdatavalid(s_readdatavalid),
    .s_readdata     (s_readdata),
    .err_timeout    (err_timeout)
  );

endmodule

// File: tb/tb_pr_avmm_freeze_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level model of the bridge.
module tb_pr_avmm_freeze_bridge;

  localparam int          ADDR_W = 20;
  localparam int          DATA_W = 32;
  localparam int          MAXO   = 4;
  localparam int          TMO    = 1024;
  localparam logic [31:0] TDATA  = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] s_address = '0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic              s_write = 1'b0;
  logic              s_read = 1'b0;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic              m_write;
  logic              m_read;
  logic              m_waitrequest = 1'b0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              freeze = 1'b0;
  logic              freeze_ack;
  logic              err_clear = 1'b0;
  logic              err_timeout;

  always #5 clk = ~clk;

  pr_avmm_freeze_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_DATA   (TDATA)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_address      (s_address),
    .s_writedata    (s_writedata),
    .s_write        (s_write),
    .s_read         (s_read),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_write        (m_write),
    .m_read         (m_read),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .freeze         (freeze),
    .freeze_ack     (freeze_ack),
    .err_clear      (err_clear),
    .err_timeout    (err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request slot, a count of unanswered reads, the edge at which the
  // response deadline was last restarted, and a count of timed-out reads.
  bit                mb_busy, mb_wr, mb_rd;
  logic [ADDR_W-1:0] mb_addr;
  logic [DATA_W-1:0] mb_data;
  int                pend, drops, tstart, edge_n;
  bit                err_m, ack_m, rv_m;
  logic [DATA_W-1:0] rd_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_busy = 0; mb_wr = 0; mb_rd = 0; mb_addr = '0; mb_data = '0;
      pend = 0; drops = 0; tstart = 0; edge_n = 0;
      err_m = 0; ack_m = 0; rv_m = 0; rd_m = '0;
    end else begin
      bit idle, acc, leave, fwd, disc, tmo;
      edge_n++;
      idle  = !mb_busy;
      acc   = idle && !freeze && (s_write || s_read) && (!s_read || pend < MAXO);
      leave = mb_busy && !m_waitrequest;
      fwd   = m_readdatavalid && (drops == 0);
      disc  = m_readdatavalid && (drops > 0);
      tmo   = !fwd && (pend > 0) && (edge_n - tstart == TMO);
      ack_m = freeze && idle && (pend == 0);
      rv_m  = fwd || tmo;
      if (fwd) rd_m = m_readdata;
      else if (tmo) rd_m = TDATA;
      if (pend == 0 || fwd || tmo) tstart = edge_n;
      pend = pend + ((leave && mb_rd) ? 1 : 0) - ((fwd && pend > 0) ? 1 : 0) - (tmo ? 1 : 0);
      drops = drops + (tmo ? 1 : 0) - (disc ? 1 : 0);
      if (tmo) err_m = 1;
      else if (err_clear) err_m = 0;
      if (acc) begin
        mb_busy = 1; mb_addr = s_address; mb_data = s_writedata;
        mb_wr = s_write; mb_rd = s_read && !s_write;
      end else if (leave) begin
        mb_busy = 0; mb_wr = 0; mb_rd = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit wx;
    wx = !(!mb_busy && !freeze && (!s_read || pend < MAXO));
    chk("s_waitrequest", s_waitrequest, wx);
    chk("m_write", m_write, mb_wr);
    chk("m_read", m_read, mb_rd);
    if (mb_busy) begin
      chk("m_address", m_address, mb_addr);
      chk("m_writedata", m_writedata, mb_data);
    end
    chk("s_readdatavalid", s_readdatavalid, rv_m);
    if (rv_m) chk("s_readdata", s_readdata, rd_m);
    chk("freeze_ack", freeze_ack, ack_m);
    chk("err_timeout", err_timeout, err_m);
  end

  int dut_writes = 0;
  int noc_issued = 0;
  int noc_resp = 0;
  always @(posedge clk) begin
    if (rst && m_write && !m_waitrequest) dut_writes++;
    if (rst && m_read && !m_waitrequest) noc_issued++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] addr);
    s_read = 1; s_address = addr;
    #2 chk("issue_accept", s_waitrequest, 0);
    tick();
    s_read = 0;
    tick();
  endtask

  task automatic respond(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      m_readdatavalid = 1; m_readdata = base + DATA_W'(i);
      tick();
    end
    m_readdatavalid = 0;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int acc, w0, n;
    bit found;
    #2 rst = 0;
    repeat (3) tick();
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_s_rdv", s_readdatavalid, 0);
    rst = 1;
    tick();
    chk("post_rst_wait", s_waitrequest, 0);

    // Write held under NoC backpressure for 3 cycles.
    w0 = dut_writes;
    m_waitrequest = 1;
    s_write = 1; s_address = 20'h00010; s_writedata = 32'h12345678;
    #2 chk("wr_accept", s_waitrequest, 0);
    tick();
    s_write = 0; s_address = '0; s_writedata = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("wr_hold_m_write", m_write, 1);
      chk("wr_hold_addr", m_address, 20'h00010);
      chk("wr_hold_data", m_writedata, 32'h12345678);
      tick();
    end
    m_waitrequest = 0;
    #2 chk("wr_last_m_write", m_write, 1);
    tick();
    chk("wr_done_m_write", m_write, 0);
    chk("wr_single", dut_writes - w0, 1);

    // Write and read together: forwarded as a write only.
    s_write = 1; s_read = 1; s_address = 20'h00500; s_writedata = 32'h55;
    tick();
    s_write = 0; s_read = 0;
    #2 chk("wr_rd_m_write", m_write, 1);
    chk("wr_rd_m_read", m_read, 0);
    tick();
    chk("wr_rd_no_pend", pend, 0);

    // Five back-to-back reads against a depth of four.
    acc = 0;
    s_read = 1; s_address = 20'h00100;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (!s_waitrequest) acc++;
      tick();
      if (m_read) s_address = s_address + 1'b1;
    end
    chk("rd_accepts", acc, 4);
    chk("rd_blocked", s_waitrequest, 1);
    chk("model_pend4", pend, 4);
    m_readdatavalid = 1; m_readdata = 32'hC0DE0001;
    tick();
    m_readdatavalid = 0;
    chk("rd_fwd_valid", s_readdatavalid, 1);
    chk("rd_fwd_data", s_readdata, 32'hC0DE0001);
    #2 chk("rd_resume", s_waitrequest, 0);
    tick();
    s_read = 0;
    tick();
    respond(4, 32'hC0DE0010);
    repeat (2) tick();
    chk("model_pend_drained", pend, 0);

    // Read with no response: timeout, then the late response is dropped.
    s_read = 1; s_address = 20'h00200;
    tick();
    s_read = 0;
    found = 0; n = 0;
    for (int i = 1; i <= 1200 && !found; i++) begin
      tick();
      if (s_readdatavalid) begin found = 1; n = i; end
    end
    chk("tmo_found", found, 1);
    chk("tmo_latency", n, 1025);
    chk("tmo_data", s_readdata, TDATA);
    chk("tmo_err", err_timeout, 1);
    chk("model_drops", drops, 1);
    m_readdatavalid = 1; m_readdata = 32'h11112222;
    tick();
    m_readdatavalid = 0;
    chk("late_dropped", s_readdatavalid, 0);
    tick();
    chk("late_dropped2", s_readdatavalid, 0);
    chk("late_err_sticky", err_timeout, 1);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("err_cleared", err_timeout, 0);

    // Real response on the expiry cycle wins.
    s_read = 1; s_address = 20'h00300;
    tick();
    s_read = 0;
    repeat (1024) tick();
    m_readdatavalid = 1; m_readdata = 32'hA5A5A5A5;
    tick();
    m_readdatavalid = 0;
    chk("race_valid", s_readdatavalid, 1);
    chk("race_data", s_readdata, 32'hA5A5A5A5);
    chk("race_err", err_timeout, 0);
    tick();
    chk("race_no_synth", s_readdatavalid, 0);
    chk("race_err2", err_timeout, 0);

    // Freeze during ISSUE with two reads in flight.
    issue_read(20'h00600);
    issue_read(20'h00601);
    m_waitrequest = 1;
    s_write = 1; s_address = 20'h00602; s_writedata = 32'hF00D;
    tick();
    s_write = 0;
    freeze = 1;
    tick(); tick();
    #2 chk("frz_issue_hold", m_write, 1);
    m_waitrequest = 0;
    tick();
    chk("frz_issue_done", m_write, 0);
    chk("frz_ack_pending", freeze_ack, 0);
    s_read = 1; s_address = 20'h00700;
    #2 chk("frz_blocked", s_waitrequest, 1);
    respond(2, 32'hF0);
    chk("frz_last_rsp", s_readdatavalid, 1);
    chk("frz_ack_not_yet", freeze_ack, 0);
    tick();
    chk("frz_ack_rise", freeze_ack, 1);
    repeat (5) tick();
    chk("frz_no_m_read", m_read, 0);
    chk("frz_still_blocked", s_waitrequest, 1);
    freeze = 0; s_read = 0;
    tick();
    chk("frz_ack_fall", freeze_ack, 0);

    // Asynchronous reset mid-ISSUE with three reads outstanding.
    issue_read(20'h00800);
    issue_read(20'h00801);
    issue_read(20'h00802);
    chk("model_pend3", pend, 3);
    m_waitrequest = 1;
    s_read = 1; s_address = 20'h00803;
    tick();
    s_read = 0;
    #2 rst = 0;
    #1;
    chk("arst_m_read", m_read, 0);
    chk("arst_m_write", m_write, 0);
    chk("arst_m_address", m_address, 0);
    chk("arst_m_writedata", m_writedata, 0);
    chk("arst_s_rdv", s_readdatavalid, 0);
    chk("arst_s_rdata", s_readdata, 0);
    chk("arst_ack", freeze_ack, 0);
    chk("arst_err", err_timeout, 0);
    m_waitrequest = 0;
    tick(); tick();
    rst = 1;
    tick();
    for (int i = 0; i < 4; i++) issue_read(20'h00900 + ADDR_W'(i));
    chk("arst_pend4", pend, 4);
    s_read = 1;
    #2 chk("arst_full", s_waitrequest, 1);
    s_read = 0;
    respond(4, 32'h900);
    repeat (2) tick();
    noc_resp = noc_issued;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s_write = ($urandom_range(0, 3) == 0);
      s_read = ($urandom_range(0, 2) == 0);
      s_address = ADDR_W'($urandom);
      s_writedata = $urandom;
      m_waitrequest = ($urandom_range(0, 2) == 0);
      if (noc_issued > noc_resp && $urandom_range(0, 2) == 0) begin
        m_readdatavalid = 1; m_readdata = $urandom; noc_resp++;
      end else begin
        m_readdatavalid = 0;
      end
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      err_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    s_write = 0; s_read = 0; m_waitrequest = 0; m_readdatavalid = 0;
    freeze = 0; err_clear = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
